alu_mem_bridge: RTL and testbench

Parametrised successor to the byte-select store path of the ALU system, which pairs the output byte mux with the data register. It moves a DATA_WIDTH-bit ALU result into the byte-wide Memory, or assembles a multi-byte Memory read into a DATA_WIDTH-bit word, one byte per cycle under a start/busy/done handshake. It sits between the ALU/register datapath and Memory, replacing the static byte mux and the shift-in data register with a sequenced, size-aware transfer engine.

---
 rtl/alu_mem_bridge.sv | 176 +++++++++++++++++
 tb/tb_alu_mem_bridge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mem_bridge.sv
// alu_mem_bridge: sequenced byte-wide transfer engine between the ALU/register
// datapath and a byte-wide Memory.
//
// A store moves a DATA_WIDTH-bit word out one byte per cycle. A load assembles
// bytes read from Memory into a DATA_WIDTH-bit word. Both use a start/busy/done
// handshake. Bytes are little-endian: byte k goes to Addr+k, and the address
// wraps modulo 2^ADDR_WIDTH.
//
// Optional feature: define ALU_MEM_SIGNEXT_EN to add the Signed input. Loads
// shorter than a full word then sign-extend instead of zero-extend.
//
// Ports:
//   Clock, Reset             rising-edge clock; synchronous active-high reset
//   Start, Op, Size          request, 0=load/1=store, log2 byte count (clamped)
//   Addr, WData              base address and store data (latched at Start)
//   Signed                   sign-extend short loads (ALU_MEM_SIGNEXT_EN only)
//   Busy, Done               transfer in progress / one-cycle completion pulse
//   RData                    assembled load result, updated when a load completes
//   Mem_Address, Mem_Data    Memory address and write byte
//   Mem_WR, Mem_CS           write enable, active-low chip select
//   MemOut                   Memory read byte (combinational from Mem_Address)
module alu_mem_bridge #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Op,
    input  logic [1:0]            Size,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] WData,
`ifdef ALU_MEM_SIGNEXT_EN
    input  logic                  Signed,
`endif
    input  logic [7:0]            MemOut,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] RData,
    output logic [ADDR_WIDTH-1:0] Mem_Address,
    output logic [7:0]            Mem_Data,
    output logic                  Mem_WR,
    output logic                  Mem_CS
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    // Wide enough to hold BYTES itself, not just BYTES-1.
    localparam int unsigned CNT_W = $clog2(BYTES) + 1;

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e                  state_q;
    logic                    op_q;
    logic [CNT_W-1:0]        n_q;
    logic [CNT_W-1:0]        k_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   shadow_q;
`ifdef ALU_MEM_SIGNEXT_EN
    logic                    signed_q;
`endif

    logic [31:0]             req_cnt;
    logic [CNT_W-1:0]        start_n;
    logic                    start_take;
    logic                    last_byte;
    logic                    xfer;
    logic                    fill_bit;
    logic [DATA_WIDTH-1:0]   merged;
    logic [DATA_WIDTH-1:0]   ext_word;
    logic [7:0]              wbyte;

    always_comb begin
        req_cnt    = 32'd1 << Size;
        start_n    = (req_cnt > BYTES) ? CNT_W'(BYTES) : CNT_W'(req_cnt);
        // Start is only honoured when the engine is not mid-transfer.
        start_take = Start && (state_q != StXfer);
        last_byte  = (k_q == n_q - CNT_W'(1));
        xfer       = (state_q == StXfer);

        // Shadow with the byte arriving this cycle already merged in, so the
        // final byte lands in RData on the same edge that enters DONE.
        merged = shadow_q;
        wbyte  = 8'h00;
        for (int b = 0; b < int'(BYTES); b++) begin
            if (k_q == CNT_W'(b)) begin
                merged[8*b +: 8] = MemOut;
                wbyte            = wdata_q[8*b +: 8];
            end
        end

        fill_bit = 1'b0;
`ifdef ALU_MEM_SIGNEXT_EN
        for (int b = 0; b < int'(BYTES); b++) begin
            if (n_q == CNT_W'(b + 1)) fill_bit = signed_q & merged[8*b+7];
        end
`endif

        ext_word = merged;
        for (int b = 0; b < int'(BYTES); b++) begin
            if (CNT_W'(b) >= n_q) ext_word[8*b +: 8] = {8{fill_bit}};
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StIdle;
            op_q     <= 1'b0;
            n_q      <= '0;
            k_q      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            shadow_q <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            RData    <= '0;
`ifdef ALU_MEM_SIGNEXT_EN
            signed_q <= 1'b0;
`endif
        end else begin
            if (start_take) begin
                op_q     <= Op;
                n_q      <= start_n;
                k_q      <= '0;
                addr_q   <= Addr;
                wdata_q  <= WData;
                shadow_q <= '0;
`ifdef ALU_MEM_SIGNEXT_EN
                signed_q <= Signed;
`endif
            end
            unique case (state_q)
                StIdle: begin
                    Done <= 1'b0;
                    if (Start) begin
                        state_q <= StXfer;
                        Busy    <= 1'b1;
                    end
                end
                StXfer: begin
                    k_q <= k_q + CNT_W'(1);
                    if (!op_q) shadow_q <= merged;
                    if (last_byte) begin
                        state_q <= StDone;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        if (!op_q) RData <= ext_word;
                    end
                end
                StDone: begin
                    Done <= 1'b0;
                    if (Start) begin
                        state_q <= StXfer;
                        Busy    <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

    // Reset forces the bus idle immediately so an in-flight write never commits.
    always_comb begin
        Mem_CS      = Reset | ~xfer;
        Mem_WR      = xfer & op_q & ~Reset;
        Mem_Data    = (xfer && op_q) ? wbyte : 8'h00;
        Mem_Address = xfer ? addr_q + ADDR_WIDTH'(k_q) : addr_q;
    end

endmodule

// File: tb/tb_alu_mem_bridge.sv
// Directed bench for alu_mem_bridge (DATA_WIDTH=32, ADDR_WIDTH=16, default build).
module tb_alu_mem_bridge;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Op;
    logic [1:0]  Size;
    logic [15:0] Addr;
    logic [31:0] WData;
    logic [7:0]  MemOut;
    logic        Busy;
    logic        Done;
    logic [31:0] RData;
    logic [15:0] Mem_Address;
    logic [7:0]  Mem_Data;
    logic        Mem_WR;
    logic        Mem_CS;

    int n_vec = 0;
    int n_err = 0;

    // Byte-wide memory model; preload port shares the write process.
    logic [7:0]  mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    assign MemOut = mem[Mem_Address];

    always @(posedge Clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (!Mem_CS && Mem_WR) mem[Mem_Address] <= Mem_Data;
    end

    always #5 Clock = ~Clock;

    alu_mem_bridge #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Op         (Op),
        .Size       (Size),
        .Addr       (Addr),
        .WData      (WData),
        .MemOut     (MemOut),
        .Busy       (Busy),
        .Done       (Done),
        .RData      (RData),
        .Mem_Address(Mem_Address),
        .Mem_Data   (Mem_Data),
        .Mem_WR     (Mem_WR),
        .Mem_CS     (Mem_CS)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] st_bytes [4];
        st_bytes[0] = 8'hD4;
        st_bytes[1] = 8'hC3;
        st_bytes[2] = 8'hB2;
        st_bytes[3] = 8'hA1;

        Reset = 1'b1;
        Start = 1'b0;
        Op    = 1'b0;
        Size  = 2'd0;
        Addr  = 16'h5A5A;
        WData = 32'hDEADBEEF;
        tick();
        tick();
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_rdata", RData, 32'h0);
        chk("rst_cs", Mem_CS, 1'b1);
        chk("rst_wr", Mem_WR, 1'b0);
        chk("rst_data", Mem_Data, 8'h00);
        chk("rst_addr", Mem_Address, 16'h0000);
        Reset = 1'b0;

        preload(16'hFFFF, 8'h34);
        preload(16'h0000, 8'h12);
        preload(16'h0301, 8'h00);

        // 4-byte store at 0x0100; inputs scrambled after the Start cycle.
        Start = 1'b1; Op = 1'b1; Size = 2'd2; Addr = 16'h0100; WData = 32'hA1B2C3D4;
        tick();
        Start = 1'b0; Op = 1'b0; Addr = 16'h7777; WData = 32'h0; Size = 2'd0;
        for (int k = 0; k < 4; k++) begin
            chk("st_busy", Busy, 1'b1);
            chk("st_cs", Mem_CS, 1'b0);
            chk("st_wr", Mem_WR, 1'b1);
            chk("st_addr", Mem_Address, 16'h0100 + 16'(k));
            chk("st_data", Mem_Data, st_bytes[k]);
            chk("st_nodone", Done, 1'b0);
            tick();
        end
        chk("st_done", Done, 1'b1);
        chk("st_done_busy", Busy, 1'b0);
        chk("st_done_cs", Mem_CS, 1'b1);
        chk("st_done_addr", Mem_Address, 16'h0100);
        chk("st_rdata_kept", RData, 32'h0);
        chk("st_mem0", mem[16'h0100], 8'hD4);
        chk("st_mem1", mem[16'h0101], 8'hC3);
        chk("st_mem2", mem[16'h0102], 8'hB2);
        chk("st_mem3", mem[16'h0103], 8'hA1);
        tick();
        chk("st_done_pulse", Done, 1'b0);

        // 2-byte load wrapping from 0xFFFF to 0x0000.
        Start = 1'b1; Op = 1'b0; Size = 2'd1; Addr = 16'hFFFF;
        tick();
        Start = 1'b0;
        chk("wr_addr0", Mem_Address, 16'hFFFF);
        chk("wr_cs", Mem_CS, 1'b0);
        chk("wr_wr", Mem_WR, 1'b0);
        tick();
        chk("wr_addr1", Mem_Address, 16'h0000);
        tick();
        chk("wr_done", Done, 1'b1);
        chk("wr_rdata", RData, 32'h00001234);
        tick();

        // Size=3 clamps to 4 bytes.
        Start = 1'b1; Op = 1'b0; Size = 2'd3; Addr = 16'h0100;
        tick();
        Start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("cl_busy", Busy, 1'b1);
            chk("cl_nodone", Done, 1'b0);
            tick();
        end
        chk("cl_done", Done, 1'b1);
        chk("cl_rdata", RData, 32'hA1B2C3D4);
        tick();

        // Start held high: load(1) -> store(1) -> load(2), back-to-back.
        Start = 1'b1; Op = 1'b0; Size = 2'd0; Addr = 16'h0102;
        tick();
        chk("bb_c1_busy", Busy, 1'b1);
        chk("bb_c1_addr", Mem_Address, 16'h0102);
        Op = 1'b1; WData = 32'h00000055; Addr = 16'h0200;
        tick();
        chk("bb_c2_done", Done, 1'b1);
        chk("bb_c2_busy", Busy, 1'b0);
        chk("bb_c2_rdata", RData, 32'h000000B2);
        tick();
        chk("bb_c3_done", Done, 1'b0);
        chk("bb_c3_wr", Mem_WR, 1'b1);
        chk("bb_c3_addr", Mem_Address, 16'h0200);
        chk("bb_c3_data", Mem_Data, 8'h55);
        Op = 1'b0; Addr = 16'h0100; Size = 2'd1;
        tick();
        chk("bb_c4_done", Done, 1'b1);
        chk("bb_c4_rdata", RData, 32'h000000B2);
        chk("bb_mem200", mem[16'h0200], 8'h55);
        tick();
        Start = 1'b0;
        chk("bb_c5_addr", Mem_Address, 16'h0100);
        chk("bb_c5_done", Done, 1'b0);
        tick();
        chk("bb_c6_addr", Mem_Address, 16'h0101);
        chk("bb_c6_done", Done, 1'b0);
        tick();
        chk("bb_c7_done", Done, 1'b1);
        chk("bb_c7_rdata", RData, 32'h0000C3D4);
        tick();

        // Reset in cycle 2 of a 4-byte store.
        Start = 1'b1; Op = 1'b1; Size = 2'd2; Addr = 16'h0300; WData = 32'h11223344;
        tick();
        Start = 1'b0;
        chk("rs_c1_data", Mem_Data, 8'h44);
        tick();
        Reset = 1'b1;
        #1;
        chk("rs_c2_cs", Mem_CS, 1'b1);
        chk("rs_c2_wr", Mem_WR, 1'b0);
        tick();
        chk("rs_busy", Busy, 1'b0);
        chk("rs_done", Done, 1'b0);
        chk("rs_cs", Mem_CS, 1'b1);
        chk("rs_addr", Mem_Address, 16'h0000);
        chk("rs_data", Mem_Data, 8'h00);
        chk("rs_rdata", RData, 32'h0);
        Reset = 1'b0;
        tick();
        chk("rs_after_done", Done, 1'b0);
        tick();
        chk("rs_after_done2", Done, 1'b0);
        chk("rs_mem300", mem[16'h0300], 8'h44);
        chk("rs_mem301", mem[16'h0301], 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
